// File: rtl/tdm_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/tdm_demux_1x4_dec.sv
// 2-to-4 one-hot write-enable decoder: raises the enable of the slot being
// written when the qualifying valid is high.
module demux_dec_2x4
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  input  logic              valid,
  output logic [NUM_CH-1:0] we
);

  always_comb begin
    we = '0;
    if (valid) we[slot] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_1x4.sv
// 1:4 TDM demultiplexer: aligns on sync, stages channels 0..2 and publishes a
// full frame on the slot-3 sample. Optional parity checking: TDM_DEMUX_PARITY_EN.
module tdm_demux_1x4
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic         din_par,
  output logic         par_err,
`endif
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err
);

  state_t              state;
  slot_t               slot;
  logic [W-1:0]        stg0, stg1, stg2;
  logic [NUM_CH-1:0]   slot_we;
  logic                start;
  logic                frame_ok;

  // A sync-qualified sample always opens a new frame, from either state.
  assign start = din_valid & sync;

  // Enables cover non-sync samples while locked; we[0] flags a missing sync.
  demux_dec_2x4 u_dec (
    .slot  (slot),
    .valid (din_valid & (state == LOCKED) & ~sync),
    .we    (slot_we)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic par_bad;
  logic frm_bad;

  assign par_bad  = din_valid & (^{din, din_par});
  assign frame_ok = ~(frm_bad | par_bad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err <= 1'b0;
      frm_bad <= 1'b0;
    end else begin
      par_err <= par_bad;
      if (start) frm_bad <= par_bad;
      else if (|slot_we[3:1]) frm_bad <= frm_bad | par_bad;
    end
  end
`else
  assign frame_ok = 1'b1;
`endif

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      slot        <= '0;
      stg0        <= '0;
      stg1        <= '0;
      stg2        <= '0;
      ch0         <= '0;
      ch1         <= '0;
      ch2         <= '0;
      ch3         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (start) begin
        // A sync in the middle of a frame abandons the partial frame.
        stg0     <= din;
        slot     <= slot_t'(1);
        state    <= LOCKED;
        sync_err <= (state == LOCKED) && (slot != '0);
      end else if (slot_we[0]) begin
        sync_err <= 1'b1;
        state    <= HUNT;
      end
      if (slot_we[1]) begin
        stg1 <= din;
        slot <= slot_t'(2);
      end
      if (slot_we[2]) begin
        stg2 <= din;
        slot <= slot_t'(3);
      end
      if (slot_we[3]) begin
        slot <= '0;
        if (frame_ok) begin
          ch0         <= stg0;
          ch1         <= stg1;
          ch2         <= stg2;
          ch3         <= din;
          frame_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Self-checking bench for tdm_demux_1x4 against a frame-level queue model.
module tb_tdm_demux_1x4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] ch0, ch1, ch2, ch3;
  logic         frame_valid, locked, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic         din_par;
  logic         par_err;
`endif

  tdm_demux_1x4 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
`ifdef TDM_DEMUX_PARITY_EN
    .din_par     (din_par),
    .par_err     (par_err),
`endif
    .ch0         (ch0),
    .ch1         (ch1),
    .ch2         (ch2),
    .ch3         (ch3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of frames the model expects the DUT to publish.
  logic [4*W-1:0] exp_q[$];

  // Frame-level reference model.
  bit           m_locked;
  logic [W-1:0] m_frame[$];
  logic [W-1:0] m_ch[4];
  bit           m_fv, m_serr, m_perr, m_bad;
  bit           par_flip = 1'b0;

  logic [4*W-1:0] dut_word;
  assign dut_word = {ch3, ch2, ch1, ch0};

  function automatic logic [4*W-1:0] model_word();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_frame.delete();
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    m_fv = 0; m_serr = 0; m_perr = 0; m_bad = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit bad);
    m_fv = 0; m_serr = 0; m_perr = v && bad;
    if (!v) return;
    if (s) begin
      if (m_locked && m_frame.size() != 0) m_serr = 1;
      m_locked = 1;
      m_frame.delete();
      m_frame.push_back(d);
      m_bad = bad;
    end else if (m_locked) begin
      if (m_frame.size() == 0) begin
        m_serr   = 1;
        m_locked = 0;
      end else begin
        m_frame.push_back(d);
        m_bad = m_bad | bad;
        if (m_frame.size() == 4) begin
          if (!m_bad) begin
            for (int i = 0; i < 4; i++) m_ch[i] = m_frame[i];
            m_fv = 1;
            exp_q.push_back({m_frame[3], m_frame[2], m_frame[1], m_frame[0]});
          end
          m_frame.delete();
        end
      end
    end
  endtask

  // Drive one cycle on the falling edge, then observe #1 after the rising edge.
  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    din_valid = v; sync = s; din = d;
`ifdef TDM_DEMUX_PARITY_EN
    din_par = (^d) ^ par_flip;
`endif
    @(posedge clk);
    #1;
    model_step(v, s, d, par_flip);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b0; sync = 1'b0; din = '0;
`ifdef TDM_DEMUX_PARITY_EN
    din_par = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (dut_word !== '0) begin
      failures++; $display("FAIL reset_ch got=%h exp=0", dut_word);
    end
    checks++;
    if ({frame_valid, sync_err, locked} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got fv=%b serr=%b lk=%b exp 000", frame_valid, sync_err, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_drop_before_sync();
    logic [W-1:0] vals[6] = '{8'hAA, 8'hBB, 8'h20, 8'h21, 8'h22, 8'h23};
    bit           syn[6]  = '{0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, syn[i], vals[i]);
      checks++;
      if ({frame_valid, sync_err, locked} !== {m_fv, m_serr, m_locked}) begin
        failures++;
        $display("FAIL drop_flags[%0d] got fv=%b serr=%b lk=%b exp fv=%b serr=%b lk=%b",
                 i, frame_valid, sync_err, locked, m_fv, m_serr, m_locked);
      end
    end
    checks++;
    if (dut_word !== 32'h23222120) begin
      failures++; $display("FAIL drop_frame got=%h exp=23222120", dut_word);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, W'(8'h10 + i));
      checks++;
      if ({frame_valid, sync_err, locked} !== {m_fv, m_serr, m_locked}) begin
        failures++;
        $display("FAIL basic_flags[%0d] got fv=%b serr=%b lk=%b exp fv=%b serr=%b lk=%b",
                 i, frame_valid, sync_err, locked, m_fv, m_serr, m_locked);
      end
    end
    checks++;
    if (dut_word !== 32'h13121110 || frame_valid !== 1'b1 || locked !== 1'b1) begin
      failures++; $display("FAIL basic_frame got=%h fv=%b lk=%b exp=13121110 fv=1 lk=1", dut_word, frame_valid, locked);
    end
    drive(0, 0, '0);
    checks++;
    if (frame_valid !== 1'b0 || dut_word !== 32'h13121110) begin
      failures++; $display("FAIL basic_hold got fv=%b ch=%h exp fv=0 ch=13121110", frame_valid, dut_word);
    end
  endtask

  task automatic test_back_to_back();
    int last   = -1;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, (i % 4) == 0, W'($urandom_range(0, 255)));
      if (frame_valid === 1'b1) begin
        pulses++;
        checks++;
        if (dut_word !== model_word()) begin
          failures++; $display("FAIL b2b_frame got=%h exp=%h", dut_word, model_word());
        end
        if (last >= 0) begin
          checks++;
          if (i - last != 4) begin
            failures++; $display("FAIL b2b_spacing got=%0d exp=4", i - last);
          end
        end
        last = i;
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_early_sync();
    logic [W-1:0] vals[6] = '{8'h30, 8'h31, 8'h40, 8'h41, 8'h42, 8'h43};
    bit           syn[6]  = '{1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, syn[i], vals[i]);
      checks++;
      if ({frame_valid, sync_err, locked} !== {m_fv, m_serr, m_locked}) begin
        failures++;
        $display("FAIL early_flags[%0d] got fv=%b serr=%b lk=%b exp fv=%b serr=%b lk=%b",
                 i, frame_valid, sync_err, locked, m_fv, m_serr, m_locked);
      end
      if (i == 2) begin
        checks++;
        if (sync_err !== 1'b1) begin
          failures++; $display("FAIL early_serr got=%b exp=1", sync_err);
        end
      end
    end
    checks++;
    if (dut_word !== 32'h43424140 || frame_valid !== 1'b1) begin
      failures++; $display("FAIL early_frame got=%h fv=%b exp=43424140 fv=1", dut_word, frame_valid);
    end
  endtask

  task automatic test_missing_sync();
    logic [4*W-1:0] prev;
    prev = dut_word;
    drive(1, 0, 8'h55);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL missing_flags got serr=%b lk=%b fv=%b exp serr=1 lk=0 fv=0", sync_err, locked, frame_valid);
    end
    drive(0, 0, '0);
    checks++;
    if (dut_word !== 32'h43424140 || locked !== 1'b0 || sync_err !== 1'b0) begin
      failures++; $display("FAIL missing_hold got ch=%h lk=%b serr=%b exp ch=43424140 lk=0 serr=0", dut_word, locked, sync_err);
    end
    checks++;
    if (dut_word !== prev) begin
      failures++; $display("FAIL missing_retain got=%h exp=%h", dut_word, prev);
    end
  endtask

  task automatic test_reset_midframe();
    drive(1, 1, 8'h60);
    drive(1, 0, 8'h61);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_word !== '0 || {frame_valid, sync_err, locked} !== 3'b000) begin
      failures++; $display("FAIL midreset got ch=%h fv=%b serr=%b lk=%b exp all 0", dut_word, frame_valid, sync_err, locked);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 8'h62);
    checks++;
    if (locked !== 1'b0 || frame_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_hunt got lk=%b fv=%b exp lk=0 fv=0", locked, frame_valid);
    end
  endtask

  task automatic test_random();
    bit v, s;
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (m_frame.size() == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      drive(v, s, W'($urandom_range(0, 255)));
      checks++;
      if ({frame_valid, sync_err, locked} !== {m_fv, m_serr, m_locked}) begin
        failures++;
        $display("FAIL rand_flags[%0d] got fv=%b serr=%b lk=%b exp fv=%b serr=%b lk=%b",
                 i, frame_valid, sync_err, locked, m_fv, m_serr, m_locked);
      end
      if (frame_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_frame got=%h exp=<none>", dut_word);
        end else begin
          logic [4*W-1:0] e;
          e = exp_q.pop_front();
          if (dut_word !== e) begin
            failures++; $display("FAIL rand_frame got=%h exp=%h", dut_word, e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  task automatic test_parity();
    logic [4*W-1:0] prev;
    drive(1, 1, 8'h70);
    prev = model_word();
    par_flip = 1'b1;
    drive(1, 0, 8'h71);
    par_flip = 1'b0;
    checks++;
    if (par_err !== 1'b1) begin
      failures++; $display("FAIL par_err got=%b exp=1", par_err);
    end
    drive(1, 0, 8'h72);
    drive(1, 0, 8'h73);
    checks++;
    if (frame_valid !== 1'b0 || dut_word !== prev || par_err !== 1'b0) begin
      failures++; $display("FAIL par_suppress got fv=%b ch=%h perr=%b exp fv=0 ch=%h perr=0", frame_valid, dut_word, par_err, prev);
    end
    for (int i = 0; i < 4; i++) drive(1, i == 0, W'(8'h80 + i));
    checks++;
    if (frame_valid !== 1'b1 || dut_word !== 32'h83828180) begin
      failures++; $display("FAIL par_recover got fv=%b ch=%h exp fv=1 ch=83828180", frame_valid, dut_word);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_drop_before_sync();
    test_basic_frame();
    test_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_reset_midframe();
    test_random();
`ifdef TDM_DEMUX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
